// File: rtl/cache_mem_pkg.sv
// cache_mem_pkg
// Shared types and constants for the cache memory-side responder.
//   resp_state_t  : responder FSM states
//   LINE_OFFSET_W : byte-offset bits inside one cache line (16-byte line)
//   BAD_DATA      : filler word returned for read beats outside the backing store
package cache_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_WAIT,
    WR_DONE,
    HOLD
  } resp_state_t;

  localparam int          LINE_OFFSET_W = 4;
  localparam logic [31:0] BAD_DATA      = 32'hDEAD_BEEF;

endpackage

// File: rtl/cache_mem_responder_mem_array.sv
// mem_array
// Single-port backing store, WORDS x 32 bits, synchronous read, no reset.
// Ports:
//   clk   in  1   clock, rising edge
//   we    in  1   write enable
//   addr  in  AW  word address (shared by read and write)
//   wdata in  32  write data
//   rdata out 32  registered read data for the address sampled at the last edge
module mem_array #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // Plain RAM: contents survive reset, read returns the pre-write value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/cache_mem_responder.sv
// cache_mem_responder
// Memory-side responder for the data cache arbiter interface. Serves line reads as
// BEATS-word bursts and single-word writebacks, each with a programmable latency.
// Ports:
//   clk         in  1   clock, rising edge
//   reset       in  1   synchronous, active-low reset
//   rd_rq       in  1   read request (level, 4-phase)
//   ar_r_addr   in  32  read byte address, line aligned internally
//   wr_rq       in  1   write request (level, 4-phase)
//   ar_w_addr   in  32  write byte address, word aligned internally
//   ar_w_data   in  32  write data
//   ar_rd_ack   out 1   read beat valid, BEATS consecutive cycles
//   rd_data     out 32  read beat data
//   ar_wr_ack   out 1   one-cycle write-accepted pulse
//   ar_wr_conf  out 1   one-cycle write-complete pulse
//   ar_wr_resp  out 1   write status with ar_wr_conf (1 = stored, 0 = out of range)
module cache_mem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int BEATS     = 4,
  parameter int RD_LAT    = 4,
  parameter int WR_LAT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_rq,
  input  logic [31:0] ar_r_addr,
  input  logic        wr_rq,
  input  logic [31:0] ar_w_addr,
  input  logic [31:0] ar_w_data,
  output logic        ar_rd_ack,
  output logic [31:0] rd_data,
  output logic        ar_wr_ack,
  output logic        ar_wr_conf,
  output logic        ar_wr_resp
);

  import cache_mem_pkg::*;

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam int          MAX_LAT   = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int          CNT_W     = $clog2(MAX_LAT + 1);
  localparam int          BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

  resp_state_t       state;
  logic [CNT_W-1:0]  lat_cnt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [29:0]       line_idx;
  logic [29:0]       wr_idx;
  logic [31:0]       wr_data;
  logic              rd_bad;

  logic [29:0]       beat_idx;
  logic              beat_in_range;
  logic              wr_in_range;
  logic              wr_commit;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_q;
  logic              unused_addr_bits;

  // Offset bits below line/word granularity carry no information here.
  assign unused_addr_bits = ^{ar_r_addr[LINE_OFFSET_W-1:0], ar_w_addr[1:0]};

  // Beat k of a burst reads word line_idx+k; the range check uses the full
  // 30-bit index so addresses that alias into the RAM are still flagged bad.
  assign beat_idx      = line_idx + 30'(beat_cnt);
  assign beat_in_range = beat_idx < MEM_LIMIT;
  assign wr_in_range   = wr_idx < MEM_LIMIT;

  // The store happens on the edge that raises ar_wr_conf; gating with reset
  // drops a write that is aborted on that very edge.
  assign wr_commit = reset && (state == WR_WAIT) && (lat_cnt == CNT_W'(WR_LAT - 1));
  assign mem_we    = wr_commit && wr_in_range;

  // RAM address is presented one cycle ahead of each beat so the registered
  // RAM output lines up with ar_rd_ack.
  always_comb begin
    mem_addr = wr_idx[AW-1:0];
    if (state == RD_BURST) begin
      mem_addr = beat_idx[AW-1:0];
    end
  end

  mem_array #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wr_data),
    .rdata (mem_q)
  );

  // Data is forced to zero outside beats so the unreset RAM output never leaks.
  assign rd_data = ar_rd_ack ? (rd_bad ? BAD_DATA : mem_q) : 32'h0;

  // Responder FSM: one operation at a time, write wins over read in IDLE,
  // HOLD waits for both requests to drop before accepting anything new.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      beat_cnt   <= '0;
      line_idx   <= '0;
      wr_idx     <= '0;
      wr_data    <= '0;
      rd_bad     <= 1'b0;
      ar_rd_ack  <= 1'b0;
      ar_wr_ack  <= 1'b0;
      ar_wr_conf <= 1'b0;
      ar_wr_resp <= 1'b0;
    end else begin
      ar_rd_ack  <= 1'b0;
      ar_wr_ack  <= 1'b0;
      ar_wr_conf <= 1'b0;
      ar_wr_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_rq) begin
            wr_idx    <= ar_w_addr[31:2];
            wr_data   <= ar_w_data;
            lat_cnt   <= '0;
            ar_wr_ack <= 1'b1;
            state     <= WR_WAIT;
          end else if (rd_rq) begin
            line_idx <= {ar_r_addr[31:LINE_OFFSET_W], (LINE_OFFSET_W - 2)'(0)};
            lat_cnt  <= '0;
            beat_cnt <= '0;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (lat_cnt == CNT_W'(RD_LAT - 1)) begin
            lat_cnt <= '0;
            state   <= RD_BURST;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        RD_BURST: begin
          ar_rd_ack <= 1'b1;
          rd_bad    <= !beat_in_range;
          if (beat_cnt == BEAT_W'(BEATS - 1)) begin
            beat_cnt <= '0;
            state    <= HOLD;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        WR_WAIT: begin
          if (wr_commit) begin
            lat_cnt    <= '0;
            ar_wr_conf <= 1'b1;
            ar_wr_resp <= wr_in_range;
            state      <= WR_DONE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        WR_DONE: begin
          state <= HOLD;
        end
        HOLD: begin
          if (!rd_rq && !wr_rq) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// tb_cache_mem_responder
// Self-checking bench for cache_mem_responder. Directed scenarios followed by
// random reads/writes, all checked against a word-level memory model.
module tb_cache_mem_responder;

  localparam int          MEM_WORDS = 1024;
  localparam int          BEATS     = 4;
  localparam int          RD_LAT    = 4;
  localparam int          WR_LAT    = 2;
  localparam logic [31:0] BAD_WORD  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd_rq = 1'b0;
  logic [31:0] ar_r_addr = '0;
  logic        wr_rq = 1'b0;
  logic [31:0] ar_w_addr = '0;
  logic [31:0] ar_w_data = '0;
  logic        ar_rd_ack;
  logic [31:0] rd_data;
  logic        ar_wr_ack;
  logic        ar_wr_conf;
  logic        ar_wr_resp;

  int checks = 0;
  int failures = 0;
  int mutex_viol = 0;

  logic [31:0] model [int unsigned];

  cache_mem_responder #(
    .MEM_WORDS (MEM_WORDS),
    .BEATS     (BEATS),
    .RD_LAT    (RD_LAT),
    .WR_LAT    (WR_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_rq      (rd_rq),
    .ar_r_addr  (ar_r_addr),
    .wr_rq      (wr_rq),
    .ar_w_addr  (ar_w_addr),
    .ar_w_data  (ar_w_data),
    .ar_rd_ack  (ar_rd_ack),
    .rd_data    (rd_data),
    .ar_wr_ack  (ar_wr_ack),
    .ar_wr_conf (ar_wr_conf),
    .ar_wr_resp (ar_wr_resp)
  );

  always #5 clk = ~clk;

  // The three handshake strobes must never overlap.
  always @(negedge clk) begin
    if (reset && (int'(ar_rd_ack) + int'(ar_wr_ack) + int'(ar_wr_conf) > 1)) begin
      mutex_viol++;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expBeat(input int unsigned idx);
    if (idx >= MEM_WORDS) return BAD_WORD;
    if (model.exists(idx)) return model[idx];
    return 32'h0;
  endfunction

  // Write one word, optionally with a read raised in the same cycle; checks
  // ack/conf timing, status and that the read waits for the write.
  task automatic applyWrite(input logic [31:0] addr, input logic [31:0] data, input bit with_read);
    int   ack_c = -1;
    int   conf_c = -1;
    int   ack_n = 0;
    int   rd_seen = 0;
    logic resp_v = 1'b0;
    logic exp_ok;
    exp_ok    = (addr >> 2) < MEM_WORDS;
    wr_rq     = 1'b1;
    ar_w_addr = addr;
    ar_w_data = data;
    if (with_read) begin
      rd_rq     = 1'b1;
      ar_r_addr = addr;
    end
    for (int c = 1; c <= 32 && conf_c < 0; c++) begin
      @(negedge clk);
      if (ar_wr_ack) begin
        ack_n++;
        if (ack_c < 0) ack_c = c;
      end
      if (ar_rd_ack) rd_seen++;
      if (ar_wr_conf) begin
        conf_c = c;
        resp_v = ar_wr_resp;
      end
    end
    @(negedge clk);
    if (ar_rd_ack) rd_seen++;
    checkOutput("wr_ack_lat", 32'(ack_c), 32'(1));
    checkOutput("wr_conf_lat", 32'(conf_c), 32'(WR_LAT + 1));
    checkOutput("wr_resp", {31'b0, resp_v}, {31'b0, exp_ok});
    checkOutput("wr_ack_once", 32'(ack_n), 32'(1));
    checkOutput("wr_conf_pulse", {31'b0, ar_wr_conf}, 32'h0);
    if (with_read) checkOutput("rd_during_wr", 32'(rd_seen), 32'h0);
    wr_rq = 1'b0;
    rd_rq = 1'b0;
    @(negedge clk);
    if (exp_ok) model[addr >> 2] = data;
  endtask

  // Read one line, keep rd_rq high for hold_extra cycles after the burst and
  // confirm no second burst starts.
  task automatic applyRead(input logic [31:0] addr, input int hold_extra);
    int          first = -1;
    int          beats = 0;
    int          extra = 0;
    int          wr_seen = 0;
    int unsigned base;
    base      = (addr >> 4) << 2;
    rd_rq     = 1'b1;
    ar_r_addr = addr;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (ar_wr_ack || ar_wr_conf) wr_seen++;
      if (ar_rd_ack) begin
        if (first < 0) first = c;
        if (beats < BEATS) begin
          checkOutput($sformatf("rd_beat%0d@%h", beats, addr), rd_data, expBeat(base + beats));
        end
        beats++;
      end else if (beats > 0) begin
        break;
      end
    end
    checkOutput("rd_lat", 32'(first), 32'(RD_LAT + 2));
    checkOutput("rd_beats", 32'(beats), 32'(BEATS));
    checkOutput("wr_during_rd", 32'(wr_seen), 32'h0);
    repeat (hold_extra) begin
      @(negedge clk);
      if (ar_rd_ack) extra++;
    end
    rd_rq = 1'b0;
    @(negedge clk);
    if (ar_rd_ack) extra++;
    checkOutput("rd_hold_quiet", 32'(extra), 32'h0);
  endtask

  // Random mix over lines 0..7 plus out-of-range addresses.
  task automatic applyStimulus(input int ops);
    logic [31:0] a;
    for (int i = 0; i < ops; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
          applyWrite(a, $urandom(), 1'b0);
        end
        1: applyWrite($urandom() | 32'h0001_0000, $urandom(), 1'b0);
        2: begin
          a = 32'($urandom_range(0, 7) * 16 + $urandom_range(0, 15));
          applyRead(a, $urandom_range(0, 3));
        end
        default: applyRead($urandom() | 32'h0001_0000, 0);
      endcase
    end
  endtask

  initial begin
    int beats;
    repeat (3) @(negedge clk);
    checkOutput("rst_rd_ack", {31'b0, ar_rd_ack}, 32'h0);
    checkOutput("rst_rd_data", rd_data, 32'h0);
    checkOutput("rst_wr_ack", {31'b0, ar_wr_ack}, 32'h0);
    checkOutput("rst_wr_conf", {31'b0, ar_wr_conf}, 32'h0);
    checkOutput("rst_wr_resp", {31'b0, ar_wr_resp}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    applyWrite(32'h0000_0010, 32'hA5A5_0001, 1'b0);
    applyRead(32'h0000_0010, 0);
    applyWrite(32'h0000_0010, 32'h11, 1'b0);
    applyWrite(32'h0000_0014, 32'h22, 1'b0);
    applyWrite(32'h0000_0018, 32'h33, 1'b0);
    applyWrite(32'h0000_001C, 32'h44, 1'b0);
    applyRead(32'h0000_001C, 0);

    applyWrite(32'h0000_0018, 32'hC0DE_0033, 1'b1);
    applyRead(32'h0000_0018, 0);

    applyWrite(32'h0001_0000, 32'h1234_5678, 1'b0);
    applyRead(32'h0001_0000, 0);

    for (int w = 1020; w < 1024; w++) applyWrite(32'(w * 4), $urandom(), 1'b0);
    applyRead(32'h0000_0FF4, 0);
    applyWrite(32'h0000_1000, 32'hFFFF_0000, 1'b0);
    applyRead(32'h0000_1008, 0);

    applyRead(32'h0000_001C, 5);

    // Reset while beat 1 is on the bus.
    beats = 0;
    rd_rq = 1'b1;
    ar_r_addr = 32'h0000_0014;
    for (int c = 1; c <= 64 && beats < 2; c++) begin
      @(negedge clk);
      if (ar_rd_ack) beats++;
    end
    checkOutput("rst_burst_reached", 32'(beats), 32'd2);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_rd_ack", {31'b0, ar_rd_ack}, 32'h0);
    checkOutput("abort_rd_data", rd_data, 32'h0);
    checkOutput("abort_wr_ack", {31'b0, ar_wr_ack}, 32'h0);
    checkOutput("abort_wr_conf", {31'b0, ar_wr_conf}, 32'h0);
    checkOutput("abort_wr_resp", {31'b0, ar_wr_resp}, 32'h0);
    reset = 1'b1;
    rd_rq = 1'b0;
    @(negedge clk);
    applyRead(32'h0000_0010, 0);

    // Reset on the commit edge discards the write.
    wr_rq = 1'b1;
    ar_w_addr = 32'h0000_0014;
    ar_w_data = 32'hBAD0_BAD0;
    repeat (WR_LAT) @(negedge clk);
    reset = 1'b0;
    wr_rq = 1'b0;
    @(negedge clk);
    checkOutput("abort_wr_noconf", {31'b0, ar_wr_conf}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    applyRead(32'h0000_0010, 0);

    for (int w = 0; w < 32; w++) applyWrite(32'(w * 4), $urandom(), 1'b0);
    applyStimulus(60);

    checkOutput("strobe_mutex", 32'(mutex_viol), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
